// File: rtl/duck_round_ctrl.sv
// rtl/duck_round_ctrl.sv - Duck Hunt round sequencer, one step per video frame.
// Optional per-round fly-time shortening under DUCK_CTRL_DIFFICULTY_EN.
module duck_round_ctrl #(
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int FLY_FRAMES      = 300,
    parameter int FALL_FRAMES     = 60,
    parameter int ESCAPE_FRAMES   = 90
`ifdef DUCK_CTRL_DIFFICULTY_EN
    ,
    parameter int FLY_STEP        = 16,
    parameter int FLY_MIN         = 120
`endif
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start_btn,
    input  logic       click,
    input  logic       kill,
    output logic       game_active,
    output logic       duck_spawn,
    output logic [1:0] duck_state,
    output logic [1:0] shots_left,
    output logic [3:0] ducks_left,
    output logic [3:0] round_hits,
    output logic [7:0] round_num,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_FLY    = 3'd2,
        S_FALL   = 3'd3,
        S_ESCAPE = 3'd4,
        S_TALLY  = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    localparam logic [15:0] FALL_LAST   = 16'(FALL_FRAMES - 1);
    localparam logic [15:0] ESCAPE_LAST = 16'(ESCAPE_FRAMES - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_start_prev;
    logic        r_click_prev;
    logic        r_kill_prev;
    logic        r_game_active;
    logic        r_duck_spawn;
    logic [1:0]  r_duck_state;
    logic [1:0]  r_shots_left;
    logic [3:0]  r_ducks_left;
    logic [3:0]  r_round_hits;
    logic [7:0]  r_round_num;
    logic        r_game_over;

    logic        w_start_rise;
    logic        w_click_rise;
    logic        w_kill_rise;
    logic [15:0] w_fly_limit;
    logic        w_fly_timeout;
    logic        w_anim_done;

    assign w_start_rise = start_btn & ~r_start_prev;
    assign w_click_rise = click & ~r_click_prev;
    assign w_kill_rise  = kill & ~r_kill_prev;

`ifdef DUCK_CTRL_DIFFICULTY_EN
    // Signed 17-bit so a late round drives the difference negative and clamps to the floor.
    logic signed [16:0] w_round_m1;
    logic signed [16:0] w_fly_calc;
    assign w_round_m1  = $signed({9'd0, r_round_num}) - 17'sd1;
    assign w_fly_calc  = $signed(17'(FLY_FRAMES)) - w_round_m1 * $signed(17'(FLY_STEP));
    assign w_fly_limit = (w_fly_calc < $signed(17'(FLY_MIN))) ? 16'(FLY_MIN) : w_fly_calc[15:0];
`else
    assign w_fly_limit = 16'(FLY_FRAMES);
`endif

    assign w_fly_timeout = (r_timer == w_fly_limit - 16'd1);
    assign w_anim_done   = (r_timer == ((r_state == S_FALL) ? FALL_LAST : ESCAPE_LAST));

    assign game_active = r_game_active;
    assign duck_spawn  = r_duck_spawn;
    assign duck_state  = r_duck_state;
    assign shots_left  = r_shots_left;
    assign ducks_left  = r_ducks_left;
    assign round_hits  = r_round_hits;
    assign round_num   = r_round_num;
    assign game_over   = r_game_over;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_start_prev  <= 1'b1;
            r_click_prev  <= 1'b1;
            r_kill_prev   <= 1'b1;
            r_game_active <= 1'b0;
            r_duck_spawn  <= 1'b0;
            r_duck_state  <= 2'd0;
            r_shots_left  <= 2'd0;
            r_ducks_left  <= 4'd0;
            r_round_hits  <= 4'd0;
            r_round_num   <= 8'd0;
            r_game_over   <= 1'b0;
        end else begin
            r_start_prev <= start_btn;
            r_click_prev <= click;
            r_kill_prev  <= kill;
            r_timer      <= r_timer + 16'd1;
            r_duck_spawn <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_state       <= S_SPAWN;
                        r_timer       <= '0;
                        r_round_num   <= 8'd1;
                        r_ducks_left  <= 4'(DUCKS_PER_ROUND);
                        r_round_hits  <= 4'd0;
                        r_game_active <= 1'b1;
                        r_duck_spawn  <= 1'b1;
                    end
                end
                S_SPAWN: begin
                    r_state      <= S_FLY;
                    r_timer      <= '0;
                    r_shots_left <= 2'(SHOTS_PER_DUCK);
                    r_duck_state <= 2'd1;
                end
                S_FLY: begin
                    // A hit wins over everything; a click in the same frame still spends a shot.
                    if (w_kill_rise) begin
                        r_state      <= S_FALL;
                        r_timer      <= '0;
                        r_duck_state <= 2'd2;
                        if (r_round_hits != 4'hf)
                            r_round_hits <= r_round_hits + 4'd1;
                        if (w_click_rise && r_shots_left != 2'd0)
                            r_shots_left <= r_shots_left - 2'd1;
                    end else if (r_shots_left == 2'd0 || w_fly_timeout) begin
                        r_state      <= S_ESCAPE;
                        r_timer      <= '0;
                        r_duck_state <= 2'd3;
                    end else if (w_click_rise) begin
                        r_shots_left <= r_shots_left - 2'd1;
                    end
                end
                S_FALL, S_ESCAPE: begin
                    if (w_anim_done) begin
                        r_timer      <= '0;
                        r_duck_state <= 2'd0;
                        r_ducks_left <= r_ducks_left - 4'd1;
                        if (r_ducks_left == 4'd1) begin
                            r_state <= S_TALLY;
                        end else begin
                            r_state      <= S_SPAWN;
                            r_duck_spawn <= 1'b1;
                        end
                    end
                end
                S_TALLY: begin
                    r_timer <= '0;
                    if (int'(r_round_hits) >= PASS_HITS) begin
                        r_state      <= S_SPAWN;
                        r_duck_spawn <= 1'b1;
                        r_ducks_left <= 4'(DUCKS_PER_ROUND);
                        r_round_hits <= 4'd0;
                        if (r_round_num != 8'hff)
                            r_round_num <= r_round_num + 8'd1;
                    end else begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end
                end
                S_OVER: begin
                    // game_active stays high here so the canvas keeps showing the score.
                    if (w_start_rise) begin
                        r_state       <= S_IDLE;
                        r_timer       <= '0;
                        r_game_active <= 1'b0;
                        r_game_over   <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_timer       <= '0;
                    r_game_active <= 1'b0;
                    r_game_over   <= 1'b0;
                    r_duck_state  <= 2'd0;
                end
            endcase
        end
    end

endmodule
